par_serializer: RTL and testbench

Parametrised parallel-to-serial shifter for the UART transmit path, generalising the fixed 8-bit serializer. It captures a DATA_WIDTH-bit word on a load strobe and shifts it out one bit per SER_EN tick, in configurable bit order. It signals completion with a one-cycle pulse and can optionally append a parity bit. It sits between the TX control FSM and the output mux, with SER_EN normally driven by the baud tick.

---
 rtl/ser_pkg.sv | 13 +
 rtl/par_calc.sv | 14 +
 rtl/par_serializer.sv | 122 ++++++++++++
 tb/tb_par_serializer.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/ser_pkg.sv
// Shared types and constants for the parallel-to-serial shifter.
package ser_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } ser_state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/par_calc.sv
// Frame parity: XOR reduction of the data word, inverted for odd parity.
module par_calc
    import ser_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  par_typ,
    output logic                  parity_c
);

    assign parity_c = (^data) ^ (par_typ == PAR_ODD);

endmodule

// File: rtl/par_serializer.sv
// Parallel-to-serial shifter for the UART TX path.
// Define SER_PARITY_EN to append a parity bit (Par_Typ port) after the data bits.
module par_serializer
    import ser_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MSB_FIRST  = 0
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_Data,
    input  logic                  Load,
    input  logic                  SER_EN,
`ifdef SER_PARITY_EN
    input  logic                  Par_Typ,
`endif
    output logic                  SER_Data,
    output logic                  SER_Done,
    output logic                  Busy
);

`ifdef SER_PARITY_EN
    localparam int unsigned NBITS = DATA_WIDTH + 1;
`else
    localparam int unsigned NBITS = DATA_WIDTH;
`endif
    localparam int unsigned      CNT_W    = $clog2(NBITS + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NBITS - 1);

    ser_state_t       state_q, state_d;
    logic [NBITS-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ser_data_q, ser_data_d;
    logic             ser_done_q, ser_done_d;
    logic             busy_q, busy_d;
    logic [NBITS-1:0] load_word;

`ifdef SER_PARITY_EN
    logic parity_c;

    par_calc #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_par_calc (
        .data     (P_Data),
        .par_typ  (Par_Typ),
        .parity_c (parity_c)
    );
`endif

    // Word is stored in transmit order so bit 0 is always the next bit out.
    always_comb begin
        load_word = '0;
        for (int i = 0; i < int'(DATA_WIDTH); i++) begin
            load_word[i] = (MSB_FIRST != 0) ? P_Data[int'(DATA_WIDTH) - 1 - i] : P_Data[i];
        end
`ifdef SER_PARITY_EN
        load_word[NBITS-1] = parity_c;
`endif
    end

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (Load) begin
                    shreg_d = load_word;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (SER_EN) begin
                    shreg_d = {1'b0, shreg_q[NBITS-1:1]};
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_IDX) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (Load) begin
                    shreg_d = load_word;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered copies of what the next state will present.
        ser_data_d = (state_d == SHIFT) && shreg_d[0];
        ser_done_d = (state_d == DONE);
        busy_d     = (state_d == SHIFT);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            cnt_q      <= '0;
            ser_data_q <= 1'b0;
            ser_done_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            cnt_q      <= cnt_d;
            ser_data_q <= ser_data_d;
            ser_done_q <= ser_done_d;
            busy_q     <= busy_d;
        end
    end

    assign SER_Data = ser_data_q;
    assign SER_Done = ser_done_q;
    assign Busy     = busy_q;

endmodule

// File: tb/tb_par_serializer.sv
// Directed + random bench for par_serializer; LSB-first and MSB-first instances share stimulus.
module tb_par_serializer;

`ifdef SER_PARITY_EN
    localparam int NB = 9;
`else
    localparam int NB = 8;
`endif

    logic       CLK;
    logic       RST;
    logic [7:0] P_Data;
    logic       Load;
    logic       SER_EN;
`ifdef SER_PARITY_EN
    logic       Par_Typ;
`endif
    logic       sd_l, dn_l, by_l;
    logic       sd_m, dn_m, by_m;

    int errors = 0;
    int checks = 0;

    par_serializer #(.DATA_WIDTH(8), .MSB_FIRST(0)) dut_lsb (
        .CLK      (CLK),
        .RST      (RST),
        .P_Data   (P_Data),
        .Load     (Load),
        .SER_EN   (SER_EN),
`ifdef SER_PARITY_EN
        .Par_Typ  (Par_Typ),
`endif
        .SER_Data (sd_l),
        .SER_Done (dn_l),
        .Busy     (by_l)
    );

    par_serializer #(.DATA_WIDTH(8), .MSB_FIRST(1)) dut_msb (
        .CLK      (CLK),
        .RST      (RST),
        .P_Data   (P_Data),
        .Load     (Load),
        .SER_EN   (SER_EN),
`ifdef SER_PARITY_EN
        .Par_Typ  (Par_Typ),
`endif
        .SER_Data (sd_m),
        .SER_Done (dn_m),
        .Busy     (by_m)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic set_pt(input logic v);
`ifdef SER_PARITY_EN
        Par_Typ = v;
`else
        if (v === 1'bx) P_Data = P_Data;
`endif
    endtask

    task automatic chk(input string tag, input logic el, input logic em,
                       input logic ed, input logic eb);
        checks++;
        assert (sd_l === el) else begin
            errors++; $error("FAIL %s lsb SER_Data got %b exp %b", tag, sd_l, el);
        end
        checks++;
        assert (sd_m === em) else begin
            errors++; $error("FAIL %s msb SER_Data got %b exp %b", tag, sd_m, em);
        end
        checks++;
        assert (dn_l === ed) else begin
            errors++; $error("FAIL %s lsb SER_Done got %b exp %b", tag, dn_l, ed);
        end
        checks++;
        assert (dn_m === ed) else begin
            errors++; $error("FAIL %s msb SER_Done got %b exp %b", tag, dn_m, ed);
        end
        checks++;
        assert (by_l === eb) else begin
            errors++; $error("FAIL %s lsb Busy got %b exp %b", tag, by_l, eb);
        end
        checks++;
        assert (by_m === eb) else begin
            errors++; $error("FAIL %s msb Busy got %b exp %b", tag, by_m, eb);
        end
    endtask

    // One frame: bits in transmit order, SER_EN pulsed every 'period' cycles.
    task automatic frame(input logic [7:0] w, input logic pt, input int period,
                         input bit do_load, input bit chain, input logic [7:0] w2,
                         input logic pt2, input bit midload, input string tag);
        logic exp_l [0:8];
        logic exp_m [0:8];
        for (int i = 0; i < 8; i++) begin
            exp_l[i] = w[i];
            exp_m[i] = w[7-i];
        end
        exp_l[8] = (^w) ^ pt;
        exp_m[8] = (^w) ^ pt;

        if (do_load) begin
            Load = 1'b1; P_Data = w; set_pt(pt); SER_EN = (period == 1);
            @(negedge CLK);
        end
        for (int k = 0; k < NB; k++) begin
            for (int c = 0; c < period; c++) begin
                chk($sformatf("%s bit%0d", tag, k), exp_l[k], exp_m[k], 1'b0, 1'b1);
                Load   = midload && (k == 3) && (c == 0);
                P_Data = Load ? 8'hFF : 8'($urandom);
                set_pt(1'($urandom));
                SER_EN = (c == period - 1);
                @(negedge CLK);
            end
        end
        chk($sformatf("%s done", tag), 1'b0, 1'b0, 1'b1, 1'b0);
        if (chain) begin
            Load = 1'b1; P_Data = w2; set_pt(pt2); SER_EN = 1'b1;
        end else begin
            Load = 1'b0; SER_EN = 1'($urandom);
        end
        @(negedge CLK);
        if (!chain) chk($sformatf("%s idle", tag), 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [7:0] w;
        RST = 1'b1; Load = 1'b0; SER_EN = 1'b0; P_Data = 8'h00; set_pt(1'b0);
        #2 RST = 1'b0;
        #1 chk("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b1;

        // SER_EN alone in IDLE does nothing
        for (int i = 0; i < 3; i++) begin
            SER_EN = 1'b1;
            @(negedge CLK);
            chk("idle_en", 1'b0, 1'b0, 1'b0, 1'b0);
        end

        frame(8'hA5, 1'b0, 1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, "a5");
        frame(8'h96, 1'b1, 4, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, "sparse");
        frame(8'hC1, 1'b0, 2, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b0, "chain_a");
        frame(8'h3C, 1'b1, 1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, "chain_b");
        frame(8'h07, 1'b0, 1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, "par_even");
        frame(8'h07, 1'b1, 1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, "par_odd");

        // Reset mid-frame after bit 3
        w = 8'hE7;
        Load = 1'b1; P_Data = w; SER_EN = 1'b1;
        @(negedge CLK);
        Load = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("abort bit%0d", k), w[k], w[7-k], 1'b0, 1'b1);
            @(negedge CLK);
        end
        #1 RST = 1'b0;
        #1 chk("abort async", 1'b0, 1'b0, 1'b0, 1'b0);
        Load = 1'b1; P_Data = 8'h55;
        @(negedge CLK);
        chk("abort held", 1'b0, 1'b0, 1'b0, 1'b0);
        RST = 1'b1; Load = 1'b0;
        @(negedge CLK);
        chk("abort no_done", 1'b0, 1'b0, 1'b0, 1'b0);
        frame(8'h5B, 1'b0, 1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, "fresh");

        for (int r = 0; r < 6; r++) begin
            frame(8'($urandom), 1'($urandom), int'($urandom_range(1, 3)),
                  1'b1, 1'($urandom), 8'($urandom), 1'($urandom), 1'b0,
                  $sformatf("rnd%0d", r));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
